// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the writeback stage and
// a long-latency unit (mult/div, uncached load return). The writeback stage
// normally wins. LLU results wait in a small FIFO. If the FIFO head goes
// ungranted for too long, a starvation counter forces a one-cycle pipeline
// stall so that the head can drain. All register-file outputs are registered.
module wb_port_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3,
   parameter int CNT_W        = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wb_regwrite,
   input  logic [4:0]               wb_rd,
   input  logic [31:0]              wb_data,
   input  logic                     llu_valid,
   output logic                     llu_ready,
   input  logic [4:0]               llu_rd,
   input  logic [31:0]              llu_data,
   output logic                     pipe_stall,
   output logic                     rf_we,
   output logic [4:0]               rf_waddr,
   output logic [31:0]              rf_wdata,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 37;           // {rd[4:0], data[31:0]}

   typedef enum logic {
      NORMAL = 1'b0,
      FORCE  = 1'b1
   } state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  starve_reg, starve_next;
   logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]     count_reg;
   logic [EW-1:0]     mem [DEPTH];

   logic              rf_we_reg;
   logic [4:0]        rf_waddr_reg;
   logic [31:0]       rf_wdata_reg;

   logic              full, empty, push, pop, grant_pipe, pipe_req;
   logic              head_write;
   logic [EW-1:0]     head;
   logic [4:0]        head_rd;
   logic [31:0]       head_data;

   // Occupancy-only flow control: a full FIFO never accepts, even on a pop.
   assign full       = (count_reg == CW'(DEPTH));
   assign empty      = (count_reg == '0);
   assign llu_ready  = !full;
   assign push       = llu_valid && !full;

   // Writes to $0 are not real requests and never reach the write port.
   assign pipe_req   = wb_regwrite && (wb_rd != 5'd0);

   assign head       = mem[rd_ptr_reg];
   assign head_rd    = head[36:32];
   assign head_data  = head[31:0];
   // A popped rd=0 entry is consumed but produces no write.
   assign head_write = pop && (head_rd != 5'd0);

   assign pipe_stall = (state_reg == FORCE);
   assign fifo_count = count_reg;
   assign rf_we      = rf_we_reg;
   assign rf_waddr   = rf_waddr_reg;
   assign rf_wdata   = rf_wdata_reg;

   // Grant selection, starvation tracking and next-state decision.
   always_comb begin
      state_next  = NORMAL;
      starve_next = starve_reg;
      grant_pipe  = 1'b0;
      pop         = 1'b0;
      case (state_reg)
         FORCE: begin
            // Pipeline is held; the head always owns this slot. The empty
            // guard only protects against an unreachable case.
            pop         = !empty;
            starve_next = '0;
            state_next  = NORMAL;
         end
         default: begin
            if (pipe_req) begin
               grant_pipe = 1'b1;
            end else if (!empty) begin
               pop = 1'b1;
            end
            if (empty || pop) begin
               starve_next = '0;
            end else if (starve_reg == CNT_W'(STARVE_LIMIT - 1)) begin
               starve_next = '0;
               state_next  = FORCE;
            end else begin
               starve_next = starve_reg + CNT_W'(1);
            end
         end
      endcase
   end

   // FSM and starvation counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= NORMAL;
         starve_reg <= '0;
      end else begin
         state_reg  <= state_next;
         starve_reg <= starve_next;
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {llu_rd, llu_data};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Registered write port; address/data hold when nothing is written.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we_reg    <= 1'b0;
         rf_waddr_reg <= '0;
         rf_wdata_reg <= '0;
      end else begin
         rf_we_reg <= grant_pipe || head_write;
         if (grant_pipe) begin
            rf_waddr_reg <= wb_rd;
            rf_wdata_reg <= wb_data;
         end else if (head_write) begin
            rf_waddr_reg <= head_rd;
            rf_wdata_reg <= head_data;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// Scoreboard bench: a queue-based reference model predicts each cycle's
// register-file write when stimulus is driven; the prediction is popped and
// compared one edge later together with occupancy, stall and ready.
module tb_wb_port_arbiter;

   localparam int DEPTH = 4;
   localparam int LIMIT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        llu_valid;
   logic        llu_ready;
   logic [4:0]  llu_rd;
   logic [31:0] llu_data;
   logic        pipe_stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [2:0]  fifo_count;

   wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .llu_valid(llu_valid), .llu_ready(llu_ready),
      .llu_rd(llu_rd), .llu_data(llu_data),
      .pipe_stall(pipe_stall),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   ent_t m_fifo[$];     // model of FIFO contents
   ent_t pend[$];       // LLU results not yet accepted
   exp_t exp_q[$];      // scoreboard of predicted writes
   bit   m_force;
   int   m_starve;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // One clock: drive inputs, predict, clock, compare.
   task automatic cycle(input bit wr, input logic [4:0] rd, input logic [31:0] data);
      exp_t e;
      ent_t h;
      bit   lv, pop, accept;
      lv          = (pend.size() > 0);
      wb_regwrite = wr;
      wb_rd       = rd;
      wb_data     = data;
      llu_valid   = lv;
      llu_rd      = lv ? pend[0].rd : 5'd0;
      llu_data    = lv ? pend[0].data : 32'd0;

      e      = '{we: 1'b0, rd: 5'd0, data: 32'd0};
      pop    = 1'b0;
      accept = lv && (m_fifo.size() != DEPTH);
      if (m_force) begin
         pop     = 1'b1;
         m_force = 1'b0;
      end else if (wr && rd != 5'd0) begin
         e = '{we: 1'b1, rd: rd, data: data};
         if (m_fifo.size() > 0) begin
            m_starve++;
            if (m_starve == LIMIT) begin
               m_force  = 1'b1;
               m_starve = 0;
            end
         end else begin
            m_starve = 0;
         end
      end else if (m_fifo.size() > 0) begin
         pop = 1'b1;
      end else begin
         m_starve = 0;
      end
      if (pop) begin
         h        = m_fifo.pop_front();
         m_starve = 0;
         if (h.rd != 5'd0) e = '{we: 1'b1, rd: h.rd, data: h.data};
      end
      if (accept) m_fifo.push_back(pend.pop_front());
      if (e.we) begin
         m_addr = e.rd;
         m_data = e.data;
      end
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      cyc++;
      e = exp_q.pop_front();
      $display("cyc=%0d we=%0b addr=%0d data=%h cnt=%0d stall=%0b rdy=%0b",
               cyc, rf_we, rf_waddr, rf_wdata, fifo_count, pipe_stall, llu_ready);
      check("rf_we",      32'(rf_we),      32'(e.we));
      check("rf_waddr",   32'(rf_waddr),   32'(m_addr));
      check("rf_wdata",   rf_wdata,        m_data);
      check("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
      check("pipe_stall", 32'(pipe_stall), 32'(m_force));
      check("llu_ready",  32'(llu_ready),  32'(m_fifo.size() != DEPTH));
   endtask

   // Present a pipe request, re-presenting it while the pipeline is held.
   task automatic pipe_req(input bit wr, input logic [4:0] rd, input logic [31:0] data);
      bit held;
      for (int k = 0; k < 3; k++) begin
         held = m_force;
         cycle(wr, rd, data);
         if (!held) break;
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 60; n++) begin
         if (m_fifo.size() == 0 && pend.size() == 0) break;
         cycle(1'b0, 5'd0, 32'd0);
      end
      check("drain_empty", 32'(fifo_count), 32'd0);
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      wb_regwrite = 1'b0;
      wb_rd       = 5'd0;
      wb_data     = 32'd0;
      llu_valid   = 1'b0;
      llu_rd      = 5'd0;
      llu_data    = 32'd0;
      m_fifo.delete();
      pend.delete();
      exp_q.delete();
      m_force  = 1'b0;
      m_starve = 0;
      m_addr   = 5'd0;
      m_data   = 32'd0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         cyc++;
         $display("cyc=%0d reset cnt=%0d we=%0b stall=%0b rdy=%0b",
                  cyc, fifo_count, rf_we, pipe_stall, llu_ready);
         check("rst_fifo_count", 32'(fifo_count), 32'd0);
         check("rst_rf_we",      32'(rf_we),      32'd0);
         check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
         check("rst_llu_ready",  32'(llu_ready),  32'd1);
         check("rst_rf_waddr",   32'(rf_waddr),   32'd0);
         check("rst_rf_wdata",   rf_wdata,        32'd0);
      end
      reset = 1'b0;
   endtask

   initial begin
      ent_t t;
      int   sent;

      do_reset();

      // Idle pipe drain.
      pend.push_back('{rd: 5'd5, data: 32'hAAAA0001});
      pend.push_back('{rd: 5'd6, data: 32'hAAAA0002});
      drain();

      // Pipe priority and forced slot.
      pend.push_back('{rd: 5'd7, data: 32'h00000077});
      for (int i = 0; i < 8; i++) pipe_req(1'b1, 5'd9, 32'(cyc));
      drain();

      // Full FIFO with a busy pipe.
      for (int i = 0; i < 5; i++) pend.push_back('{rd: 5'(10 + i), data: 32'hF000_0000 + 32'(i)});
      for (int i = 0; i < 20; i++) pipe_req(1'b1, 5'd9, 32'h100 + 32'(i));
      drain();

      // $0 handling.
      pend.push_back('{rd: 5'd3, data: 32'h33});
      cycle(1'b0, 5'd0, 32'd0);
      cycle(1'b1, 5'd0, 32'hDEAD);
      pend.push_back('{rd: 5'd0, data: 32'h1234});
      cycle(1'b1, 5'd0, 32'hBEEF);
      cycle(1'b1, 5'd0, 32'hBEEF);
      drain();

      // Wrap: 10 entries with random pipe activity.
      sent = 0;
      for (int n = 0; n < 200; n++) begin
         if (sent < 10 && $urandom_range(0, 1) == 1) begin
            t.rd   = 5'($urandom_range(0, 31));
            t.data = $urandom;
            pend.push_back(t);
            sent++;
         end
         pipe_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
         if (sent == 10 && pend.size() == 0 && m_fifo.size() == 0) break;
      end
      drain();

      // Reset mid-traffic with three entries queued.
      for (int i = 0; i < 3; i++) pend.push_back('{rd: 5'(20 + i), data: 32'h5000 + 32'(i)});
      for (int i = 0; i < 3; i++) cycle(1'b1, 5'd9, 32'h900 + 32'(i));
      check("pre_reset_count", 32'(fifo_count), 32'd3);
      do_reset();
      cycle(1'b0, 5'd0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between the writeback stage (WB_out/RD_out/ALU/MEM select) and a long-latency unit (LLU: mult/div, uncached load return).
- Writeback stage has default priority.
- LLU results are buffered in a small FIFO.
- A starvation counter forces a one-cycle pipeline stall to drain the FIFO head.
- Sits between the Writeback stage outputs and the register file write port.

Parameters:
DEPTH, 4, LLU result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO head may go ungranted before a forced slot (>=1)
CNT_W, 3, starvation counter width (must hold STARVE_LIMIT)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wb_regwrite  in  1  writeback stage requests a register write this cycle
wb_rd  in  5  writeback destination register
wb_data  in  32  writeback data (already muxed MEM/ALU)
llu_valid  in  1  LLU result offered
llu_ready  out  1  FIFO accepts result (= !full)
llu_rd  in  5  LLU destination register
llu_data  in  32  LLU result
pipe_stall  out  1  pipeline must hold its writeback inputs this cycle
rf_we  out  1  register file write enable (registered)
rf_waddr  out  5  register file write address (registered)
rf_wdata  out  32  register file write data (registered)
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (sync, highest priority): FIFO emptied, fifo_count=0, starve counter=0, FSM=NORMAL, rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0, llu_ready=1 on the following cycle. In-flight FIFO entries are discarded.
- Push: llu_valid && llu_ready. llu_ready = (fifo_count != DEPTH). This is a pure function of occupancy; no push-through-pop when full.
- Pipe request is effective when wb_regwrite && wb_rd != 0. Writes to $0 never reach rf_we.
- FSM, state register, Moore output pipe_stall:
  - NORMAL: pipe_stall=0.
    - Effective pipe request: grant pipe.
    - Otherwise, if FIFO non-empty: grant FIFO head (pop).
  - FORCE: pipe_stall=1. Pipe request is ignored (the pipeline holds and re-presents it next cycle). Grant FIFO head (pop). Next state NORMAL unconditionally.
- Starve counter:
  - Increments each NORMAL cycle in which the FIFO is non-empty and the head is not granted.
  - Clears on any pop or when the FIFO is empty.
  - When it would reach STARVE_LIMIT, next state is FORCE and the counter clears.
- FORCE with an empty FIFO is impossible, since entry requires non-empty and there is no external pop.
- Pop of an entry with rd=0: entry is removed and rf_we=0 for that slot. This still counts as a pop.
- Grant latency: the granted write appears on rf_we/rf_waddr/rf_wdata on the next clock edge (1-cycle registered). rf_we=0 when there is no grant; rf_waddr/rf_wdata hold their last values.
- Same-cycle push and pop with the FIFO non-full: both occur; count unchanged. Push into an empty FIFO is not poppable until the next cycle (no bypass).
- Ordering: FIFO entries are written strictly in arrival order.
- Pointers wrap modulo DEPTH. fifo_count never exceeds DEPTH or underflows.
- Same rd from the pipe and the FIFO head in one cycle: pipe wins. The FIFO entry is written later, so the last write wins. Hazard tracking is outside this block.

Test Plan:
- Reset: assert reset 2 cycles mid-traffic with 3 entries queued -> fifo_count=0, rf_we=0, pipe_stall=0, llu_ready=1 after the first post-reset edge.
- Idle pipe drain: wb_regwrite=0; push {rd=5, 0xAAAA0001}, then {rd=6, 0xAAAA0002} -> rf_we pulses with 5/0xAAAA0001 two cycles after the first push, then 6/0xAAAA0002; no pipe_stall.
- Pipe priority and forced slot: wb_regwrite=1 every cycle (rd=9, data=cycle#); one LLU push {rd=7, 0x77} -> 3 pipe writes, then pipe_stall=1 for exactly one cycle; the next cycle's rf write is 7/0x77; the pipe write then resumes with the held value.
- Full: pipe busy, push 5 results with DEPTH=4 -> llu_ready=0 after the 4th push and the 5th is held by the LLU; after the forced pop, llu_ready=1 and the 5th is accepted; total 5 writes in order.
- $0 handling: wb_rd=0 with wb_regwrite=1 while FIFO holds {rd=3, 0x33} -> FIFO granted, rf_waddr=3; an LLU entry with rd=0 pops with rf_we=0 and fifo_count decrements.
- Wrap: push/pop 10 entries with random pipe gaps -> all written in order, fifo_count matches the model each cycle.
